// File: rtl/stb_gen_pkg.sv
// rtl/stb_gen_pkg.sv - shared state encoding and constants for the averaging strobe generator
package stb_gen_pkg;

  typedef enum logic [5:0] {
    ST_IDLE    = 6'b000001,
    ST_SYNC    = 6'b000010,
    ST_MEASURE = 6'b000100,
    ST_CALC    = 6'b001000,
    ST_RUN     = 6'b010000,
    ST_ERR     = 6'b100000
  } state_e;

  localparam int SYNC_STAGES = 2;
  localparam int MIN_PERIOD  = 4;

endpackage

// File: rtl/sig_edge_det.sv
// rtl/sig_edge_det.sv - optional synchroniser followed by a registered rising-edge pulse
module sig_edge_det
  import stb_gen_pkg::*;
#(
  parameter bit SYNC_EN = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sig,
  output logic rise
);

  logic level;
  logic level_q;

  if (SYNC_EN) begin : g_sync
    sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .din   (sig),
      .dout  (level)
    );
  end else begin : g_direct
    assign level = sig;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      level_q <= 1'b0;
      rise    <= 1'b0;
    end else begin
      level_q <= level;
      rise    <= level & ~level_q;
    end
  end

endmodule

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - multi-stage flip-flop synchroniser for a single asynchronous bit
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic din,
  output logic dout
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= (sync_q << 1) | STAGES'(din);
    end
  end

  assign dout = sync_q[STAGES-1];

endmodule

// File: rtl/stb_gen_avg.sv
// rtl/stb_gen_avg.sv - measures an averaged input period and emits a phase-locked strobe
module stb_gen_avg
  import stb_gen_pkg::*;
#(
  parameter int CNT_WIDTH = 32,
  parameter int AVG_LOG2  = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 sig_i,
  input  logic                 start_i,
  input  logic                 mode_i,
  input  logic [CNT_WIDTH-1:0] zero_hold_i,
  input  logic [CNT_WIDTH-1:0] timeout_i,
  input  logic                 stb_req_i,
  output logic                 stb_o,
  output logic                 stb_valid_o,
  output logic [CNT_WIDTH-1:0] period_o,
  output logic                 rdy_o,
  output logic                 err_o
);

  localparam int ACC_W = CNT_WIDTH + AVG_LOG2;
  localparam int EC_W  = AVG_LOG2 + 1;
  localparam logic [EC_W-1:0]      EDGES = EC_W'(2 ** AVG_LOG2);
  localparam logic [CNT_WIDTH-1:0] ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] MIN_P = CNT_WIDTH'(MIN_PERIOD);

  state_e               state_q;
  logic                 mode_q;
  logic                 armed_q;
  logic                 emit_q;
  logic [CNT_WIDTH-1:0] zh_q;
  logic [CNT_WIDTH-1:0] tmo_q;
  logic [CNT_WIDTH-1:0] tcnt_q;
  logic [CNT_WIDTH-1:0] phase_q;
  logic [ACC_W-1:0]     acc_q;
  logic [EC_W-1:0]      ecnt_q;

  logic sig_rise;
  logic req_rise;

  sig_edge_det #(.SYNC_EN(1'b1)) u_sig_det (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .sig   (sig_i),
    .rise  (sig_rise)
  );

  sig_edge_det #(.SYNC_EN(1'b0)) u_req_det (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .sig   (stb_req_i),
    .rise  (req_rise)
  );

  logic [CNT_WIDTH-1:0] calc_period;
  logic [CNT_WIDTH-1:0] phase_nxt;
  logic [CNT_WIDTH-1:0] tcnt_inc;
  logic [ACC_W-1:0]     acc_inc;
  logic [EC_W-1:0]      ecnt_inc;
  logic                 acc_full;
  logic                 timed_out;
  logic                 bad_cfg;
  logic                 calc_lvl;
  logic                 phase_wrap;
  logic                 last_nxt;
  logic                 emit_nxt;
  logic                 req_ok;

  always_comb begin
    calc_period = acc_q[ACC_W-1:AVG_LOG2];
    acc_inc     = acc_q + ACC_W'(1);
    ecnt_inc    = ecnt_q + EC_W'(1);
    tcnt_inc    = (tcnt_q == '1) ? tcnt_q : tcnt_q + ONE;
    acc_full    = (acc_q == '1);
    // tcnt_q holds the number of cycles already elapsed since the last edge or start
    timed_out   = (tmo_q != '0) && (tcnt_q >= tmo_q - ONE);
    bad_cfg     = (calc_period < MIN_P) || (zh_q >= calc_period);
    calc_lvl    = (phase_q + ONE) < (calc_period - zh_q);
    phase_wrap  = (phase_q == period_o - ONE);
    phase_nxt   = phase_wrap ? '0 : phase_q + ONE;
    last_nxt    = (phase_nxt == period_o - ONE);
    emit_nxt    = phase_wrap ? armed_q : emit_q;
    req_ok      = req_rise && mode_q && !armed_q && !emit_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      mode_q      <= 1'b0;
      armed_q     <= 1'b0;
      emit_q      <= 1'b0;
      zh_q        <= '0;
      tmo_q       <= '0;
      tcnt_q      <= '0;
      phase_q     <= '0;
      acc_q       <= '0;
      ecnt_q      <= '0;
      stb_o       <= 1'b0;
      stb_valid_o <= 1'b0;
      period_o    <= '0;
      rdy_o       <= 1'b0;
      err_o       <= 1'b0;
    end else if (start_i) begin
      state_q     <= ST_SYNC;
      mode_q      <= mode_i;
      zh_q        <= zero_hold_i;
      tmo_q       <= timeout_i;
      tcnt_q      <= ONE;
      acc_q       <= '0;
      ecnt_q      <= '0;
      phase_q     <= '0;
      armed_q     <= 1'b0;
      emit_q      <= 1'b0;
      stb_o       <= 1'b0;
      stb_valid_o <= 1'b0;
      rdy_o       <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      stb_valid_o <= 1'b0;
      unique case (state_q)
        ST_IDLE: ;
        ST_SYNC: begin
          if (sig_rise) begin
            state_q <= ST_MEASURE;
            acc_q   <= '0;
            ecnt_q  <= '0;
            tcnt_q  <= ONE;
          end else if (timed_out) begin
            state_q <= ST_ERR;
            err_o   <= 1'b1;
            rdy_o   <= 1'b0;
            stb_o   <= 1'b0;
          end else begin
            tcnt_q <= tcnt_inc;
          end
        end
        ST_MEASURE: begin
          if (acc_full) begin
            state_q <= ST_ERR;
            err_o   <= 1'b1;
            rdy_o   <= 1'b0;
            stb_o   <= 1'b0;
          end else if (sig_rise) begin
            acc_q  <= acc_inc;
            ecnt_q <= ecnt_inc;
            tcnt_q <= ONE;
            // This final-edge cycle is phase 0, so the next cycle already sits at phase 1
            if (ecnt_inc == EDGES) begin
              state_q <= ST_CALC;
              phase_q <= ONE;
            end
          end else if (timed_out) begin
            state_q <= ST_ERR;
            err_o   <= 1'b1;
            rdy_o   <= 1'b0;
            stb_o   <= 1'b0;
          end else begin
            acc_q  <= acc_inc;
            tcnt_q <= tcnt_inc;
          end
        end
        ST_CALC: begin
          if (bad_cfg) begin
            state_q <= ST_ERR;
            err_o   <= 1'b1;
            rdy_o   <= 1'b0;
            stb_o   <= 1'b0;
          end else begin
            state_q  <= ST_RUN;
            period_o <= calc_period;
            rdy_o    <= 1'b1;
            phase_q  <= phase_q + ONE;
            stb_o    <= mode_q | calc_lvl;
          end
        end
        ST_RUN: begin
          phase_q <= phase_nxt;
          emit_q  <= emit_nxt;
          if (phase_wrap && armed_q) begin
            armed_q <= 1'b0;
          end else if (req_ok) begin
            armed_q <= 1'b1;
          end
          stb_o       <= (mode_q && !emit_nxt) || (phase_nxt < period_o - zh_q);
          stb_valid_o <= mode_q && emit_nxt && last_nxt;
        end
        ST_ERR: ;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/stb_gen_avg.md
# stb_gen_avg

Parametrised successor of the measurement-unit strobe generator. Synchronises an external periodic signal, measures its period averaged over 2^AVG_LOG2 cycles, then generates a phase-locked strobe with a programmable zero-hold window, in continuous or on-demand mode. It sits in the measure unit between the input comparator path and the sampling/strobe distribution logic; errors are reported for timeouts, overflow and bad configuration.

## Interface
- CNT_WIDTH, 32, width of all cycle counters and period values (≥ 8)
- AVG_LOG2, 2, log2 of the number of input periods averaged (0..4)
- clk_i  in  1  system clock
- rst_i  in  1  synchronous active-high reset
- sig_i  in  1  asynchronous periodic input
- start_i  in  1  single-cycle pulse, (re)starts measurement
- mode_i  in  1  0 = continuous strobe, 1 = on-demand; sampled at start_i
- zero_hold_i  in  CNT_WIDTH  strobe low-window length in cycles; sampled at start_i
- timeout_i  in  CNT_WIDTH  max cycles between input edges, 0 = disabled; sampled at start_i
- stb_req_i  in  1  on-demand request, rising-edge sensitive
- stb_o  out  1  generated strobe
- stb_valid_o  out  1  one-cycle pulse, end of a requested strobe (mode 1 only)
- period_o  out  CNT_WIDTH  averaged period in cycles
- rdy_o  out  1  strobe generation running
- err_o  out  1  sticky error, cleared by start_i or reset

## Operation
- States: IDLE, SYNC, MEASURE, CALC, RUN, ERR.
- IDLE: wait for start_i → SYNC. start_i in any state → SYNC (configuration re-sampled, rdy_o/err_o/stb_o cleared, period_o retained).
- SYNC: wait first detected rising edge of sig_i → MEASURE; edge counter and accumulator cleared.
- MEASURE: accumulator counts cycles; each detected edge increments edge counter; at the 2^AVG_LOG2-th edge → CALC and phase counter reset to 0 on that cycle.
- CALC: period = accumulator >> AVG_LOG2 (truncating); checks: period < 4 or zero_hold_i ≥ period → ERR; else → RUN, period_o updated.
- RUN: phase counter runs 0..period-1 and wraps; stb_o = 1 while phase < period − zero_hold, 0 otherwise. zero_hold = 0 gives stb_o constantly high.
- Mode 1: stb_o held 1 in RUN; a stb_req_i rising edge arms a one-shot; the next phase wrap starts a full period whose low window is emitted; stb_valid_o pulses on the last cycle (phase = period−1) of that period. Requests while armed or emitting are ignored.
- Timeout: in SYNC/MEASURE, if timeout_i ≠ 0 and cycles since last edge (or since start) reach timeout_i → ERR.
- Overflow: accumulator reaching all-ones in MEASURE → ERR.
- ERR: err_o = 1, rdy_o = 0, stb_o = 0; exit only via start_i or rst_i.
- rdy_o = 1 exactly in RUN.

## Timing
- Reset: state IDLE; stb_o, stb_valid_o, rdy_o, err_o = 0; period_o = 0; all counters 0. Reset mid-operation takes effect at the next clk_i edge regardless of state.
- sig_i → detected edge: 3 cycles (2-stage sync + edge register).
- Final edge detection → CALC: 1 cycle; CALC → RUN and period_o valid: 1 cycle. rdy_o rises 2 cycles after final edge detection.
- stb_o registered; phase 0 (stb_o high unless zero_hold ≥ period) falls on cycles k·period after final edge detection, k ≥ 1; phase counter already running during CALC.
- stb_req_i edge detection registered: 1 cycle latency to arm.
- start_i coincident with timeout/overflow: start_i wins (SYNC, err_o = 0).
- Edge coincident with timeout threshold: edge wins.

## Structure
- Package stb_gen_pkg: state enum (one-hot), SYNC_STAGES = 2, MIN_PERIOD = 4.
- Sub-module sig_edge_det: wraps existing sync_ff (SYNC_STAGES) plus rising-edge register; reused for stb_req_i without synchroniser (parameter SYNC_EN).
- Accumulator width CNT_WIDTH + AVG_LOG2 internally; overflow checked on full width's top CNT_WIDTH... saturation at all-ones of the internal accumulator.

## Test plan
- sig_i period 100 cycles, AVG_LOG2 = 2, zero_hold 10, mode 0 → period_o = 100, rdy_o high, stb_o high 90 / low 10 repeating, phase 0 every 100 cycles from final edge.
- Jittered input periods 99,101,100,102, AVG_LOG2 = 2 → period_o = 100 (truncation of 402/4).
- Mode 1, period 50, zero_hold 5, stb_req_i pulse → exactly one 5-cycle low window, stb_valid_o one cycle at phase 49; second request mid-emission ignored.
- sig_i stuck low, timeout_i = 1000 → err_o = 1 at cycle 1000 after start, stb_o = 0; start_i clears err_o.
- zero_hold_i = 100, period 100 → ERR after CALC; then rst_i mid-RUN of a valid config → all outputs 0 next cycle.
